usr_shift_sequencer: RTL and testbench



---
 rtl/usr_shift_sequencer.sv | 131 +++++++++++++
 tb/tb_usr_shift_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/usr_shift_sequencer.sv
// Command-driven sequencer for a 4-bit universal shift register: accepts one
// load/shift job, steps the register's controls, then returns its contents.
module usr_shift_sequencer #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [CNT_W-1:0] cmd_count,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             busy,
   output logic             usr_load,
   output logic             usr_shift_left,
   output logic             usr_shift_right,
   output logic [WIDTH-1:0] usr_parallel_in,
   input  logic [WIDTH-1:0] usr_q
);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SHIFT,
      DONE
   } state_t;

   state_t           state_q;
   logic             dir_q;
   logic [WIDTH-1:0] data_q;
   logic [CNT_W-1:0] remain_q;
   logic             cmdReady_q;
   logic             busy_q;
   logic             load_q;
   logic             left_q;
   logic             right_q;
   logic             rspValid_q;

   // Control outputs are registered alongside the state so each one is the
   // direct decode of where the FSM is, with at most one usr_* control high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         dir_q      <= 1'b0;
         data_q     <= '0;
         remain_q   <= '0;
         cmdReady_q <= 1'b1;
         busy_q     <= 1'b0;
         load_q     <= 1'b0;
         left_q     <= 1'b0;
         right_q    <= 1'b0;
         rspValid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cmd_valid) begin
                  dir_q      <= cmd_op[0];
                  data_q     <= cmd_data;
                  remain_q   <= cmd_count;
                  cmdReady_q <= 1'b0;
                  busy_q     <= 1'b1;
                  if (!cmd_op[1]) begin
                     state_q <= LOAD;
                     load_q  <= 1'b1;
                  end else if (cmd_count != '0) begin
                     state_q <= SHIFT;
                     left_q  <= ~cmd_op[0];
                     right_q <= cmd_op[0];
                  end else begin
                     state_q    <= DONE;
                     rspValid_q <= 1'b1;
                  end
               end
            end
            LOAD: begin
               load_q <= 1'b0;
               if (remain_q != '0) begin
                  state_q <= SHIFT;
                  left_q  <= ~dir_q;
                  right_q <= dir_q;
               end else begin
                  state_q    <= DONE;
                  rspValid_q <= 1'b1;
               end
            end
            SHIFT: begin
               remain_q <= remain_q - 1'b1;
               if (remain_q == 1) begin
                  state_q    <= DONE;
                  left_q     <= 1'b0;
                  right_q    <= 1'b0;
                  rspValid_q <= 1'b1;
               end
            end
            DONE: begin
               if (rsp_ready) begin
                  state_q    <= IDLE;
                  rspValid_q <= 1'b0;
                  busy_q     <= 1'b0;
                  cmdReady_q <= 1'b1;
               end
            end
            default: begin
               state_q    <= IDLE;
               cmdReady_q <= 1'b1;
               busy_q     <= 1'b0;
               load_q     <= 1'b0;
               left_q     <= 1'b0;
               right_q    <= 1'b0;
               rspValid_q <= 1'b0;
            end
         endcase
      end
   end

   assign cmd_ready       = cmdReady_q;
   assign busy            = busy_q;
   assign usr_load        = load_q;
   assign usr_shift_left  = left_q;
   assign usr_shift_right = right_q;
   assign rsp_valid       = rspValid_q;

   // Data buses are gated to zero outside the phase that owns them.
   assign usr_parallel_in = load_q ? data_q : '0;
   assign rsp_data        = rspValid_q ? usr_q : '0;

endmodule

// File: tb/tb_usr_shift_sequencer.sv
// Directed bench for usr_shift_sequencer with a behavioural 4-bit universal
// shift register (zero fill) closing the loop on usr_q.
module tb_usr_shift_sequencer;

   logic       clk;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [3:0] cmd_data;
   logic [2:0] cmd_count;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [3:0] rsp_data;
   logic       busy;
   logic       usr_load;
   logic       usr_shift_left;
   logic       usr_shift_right;
   logic [3:0] usr_parallel_in;
   logic [3:0] usr_q;

   int errorCount = 0;
   int checkCount = 0;

   usr_shift_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .cmd_valid       (cmd_valid),
      .cmd_ready       (cmd_ready),
      .cmd_op          (cmd_op),
      .cmd_data        (cmd_data),
      .cmd_count       (cmd_count),
      .rsp_valid       (rsp_valid),
      .rsp_ready       (rsp_ready),
      .rsp_data        (rsp_data),
      .busy            (busy),
      .usr_load        (usr_load),
      .usr_shift_left  (usr_shift_left),
      .usr_shift_right (usr_shift_right),
      .usr_parallel_in (usr_parallel_in),
      .usr_q           (usr_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Shift register the sequencer drives; shares rst_n with the controller.
   logic [3:0] srModel;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)               srModel <= 4'b0000;
      else if (usr_load)        srModel <= usr_parallel_in;
      else if (usr_shift_left)  srModel <= {srModel[2:0], 1'b0};
      else if (usr_shift_right) srModel <= {1'b0, srModel[3:1]};
   end
   assign usr_q = srModel;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, ".cmd_ready"}, 32'(cmd_ready), 32'd1);
      checkOutput({tag, ".busy"}, 32'(busy), 32'd0);
      checkOutput({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
      checkOutput({tag, ".rsp_data"}, 32'(rsp_data), 32'd0);
      checkOutput({tag, ".ctrl"}, 32'({usr_load, usr_shift_left, usr_shift_right}), 32'd0);
      checkOutput({tag, ".par_in"}, 32'(usr_parallel_in), 32'd0);
   endtask

   // expLat is the number of edges after the accept edge until rsp_valid shows.
   task automatic applyStimulus(input string name, input logic [1:0] op, input logic [3:0] data,
                                input logic [2:0] cnt, input int expLat, input int expLoads,
                                input int expLefts, input int expRights, input logic [3:0] expData,
                                input int holdCycles, input bit contend);
      int lat;
      int loads;
      int lefts;
      int rights;
      lat = 0; loads = 0; lefts = 0; rights = 0;
      @(negedge clk);
      checkOutput({name, ".ready_before"}, 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      cmd_count = cnt;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_data  = 4'h0;
      while (!rsp_valid && lat < 40) begin
         checkOutput({name, ".onehot"}, 32'(int'(usr_load) + int'(usr_shift_left) + int'(usr_shift_right) <= 1), 32'd1);
         if (usr_load) begin
            loads++;
            checkOutput({name, ".par_in"}, 32'(usr_parallel_in), 32'(data));
         end else begin
            checkOutput({name, ".par_zero"}, 32'(usr_parallel_in), 32'd0);
         end
         if (usr_shift_left)  lefts++;
         if (usr_shift_right) rights++;
         @(posedge clk);
         #1;
         lat++;
      end
      checkOutput({name, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
      checkOutput({name, ".latency"}, 32'(lat), 32'(expLat));
      checkOutput({name, ".loads"}, 32'(loads), 32'(expLoads));
      checkOutput({name, ".lefts"}, 32'(lefts), 32'(expLefts));
      checkOutput({name, ".rights"}, 32'(rights), 32'(expRights));
      checkOutput({name, ".rsp_data"}, 32'(rsp_data), 32'(expData));
      checkOutput({name, ".done_ctrl"}, 32'({usr_load, usr_shift_left, usr_shift_right}), 32'd0);
      checkOutput({name, ".done_ready"}, 32'(cmd_ready), 32'd0);
      checkOutput({name, ".done_busy"}, 32'(busy), 32'd1);
      if (contend) begin
         cmd_valid = 1'b1;
         cmd_op    = 2'b00;
         cmd_data  = 4'hF;
         cmd_count = 3'd1;
      end
      for (int i = 0; i < holdCycles; i++) begin
         @(posedge clk);
         #1;
         checkOutput({name, ".hold_valid"}, 32'(rsp_valid), 32'd1);
         checkOutput({name, ".hold_data"}, 32'(rsp_data), 32'(expData));
         checkOutput({name, ".hold_ready"}, 32'(cmd_ready), 32'd0);
         checkOutput({name, ".hold_ctrl"}, 32'({usr_load, usr_shift_left, usr_shift_right}), 32'd0);
      end
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      rsp_ready = 1'b0;
      checkIdle({name, ".after"});
   endtask

   initial begin
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      cmd_data  = 4'h0;
      cmd_count = 3'd0;
      rsp_ready = 1'b0;
      #12;
      checkIdle("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkIdle("post_reset");

      applyStimulus("left1",      2'b00, 4'b1011, 3'd1, 2, 1, 1, 0, 4'b0110, 0, 1'b0);
      applyStimulus("right2",     2'b01, 4'b1100, 3'd2, 3, 1, 0, 2, 4'b0011, 0, 1'b0);
      applyStimulus("skipLeft1",  2'b10, 4'b1111, 3'd1, 1, 0, 1, 0, 4'b0110, 0, 1'b0);
      applyStimulus("left7",      2'b00, 4'b1111, 3'd7, 8, 1, 7, 0, 4'b0000, 0, 1'b0);
      applyStimulus("load0",      2'b00, 4'b1011, 3'd0, 1, 1, 0, 0, 4'b1011, 0, 1'b0);
      applyStimulus("skip0",      2'b11, 4'b0101, 3'd0, 0, 0, 0, 0, 4'b1011, 0, 1'b0);
      applyStimulus("backpress",  2'b01, 4'b1000, 3'd3, 4, 1, 0, 3, 4'b0001, 5, 1'b1);

      // Reset in the middle of a count=5 left-shift job.
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = 2'b00;
      cmd_data  = 4'b1011;
      cmd_count = 3'd5;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      checkOutput("midjob.shifting", 32'(usr_shift_left), 32'd1);
      checkOutput("midjob.busy", 32'(busy), 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkIdle("midreset");
      checkOutput("midreset.usr_q", 32'(usr_q), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      applyStimulus("recover",    2'b01, 4'b1001, 3'd1, 2, 1, 0, 1, 4'b0100, 0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
